// File: rtl/vc_fifo_bank.sv
// Two-VC FIFO bank: words steered by data_in[4] into independent circular FIFOs.
// Optional macro VC_ALMOST_FULL_EN lowers the full threshold to DEPTH-1.
module vc_fifo_bank #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             vc0_pop,
    input  logic             vc1_pop,
    output logic [WIDTH-1:0] vc0_data,
    output logic [WIDTH-1:0] vc1_data,
    output logic             vc0_valid,
    output logic             vc1_valid,
    output logic             vc0_full,
    output logic             vc1_full,
    output logic             vc0_empty,
    output logic             vc1_empty,
    output logic             error
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);
`ifdef VC_ALMOST_FULL_EN
    // One slot of slack absorbs a push already in flight from the pop stage.
    localparam logic [PtrW:0] FullThr = (PtrW + 1)'(DEPTH - 1);
`else
    localparam logic [PtrW:0] FullThr = FullCnt;
`endif

    logic [1:0]       pop_req;
    logic [1:0]       push_req;
    logic [1:0]       overflow;
    logic [1:0]       underflow;
    logic [1:0]       valid;
    logic [1:0]       full;
    logic [1:0]       empty;
    logic [WIDTH-1:0] rd_data [2];
    logic             error_q;

    assign pop_req  = {vc1_pop, vc0_pop};
    assign push_req = {push & data_in[4], push & ~data_in[4]};

    for (genvar v = 0; v < 2; v++) begin : g_vc
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PtrW-1:0]  wptr_q;
        logic [PtrW-1:0]  rptr_q;
        logic [PtrW:0]    count_q;
        logic [WIDTH-1:0] data_q;
        logic             valid_q;
        logic             do_push;
        logic             do_pop;

        // Both decisions use the registered count, so a same-cycle push never feeds a pop.
        assign do_push      = push_req[v] && (count_q != FullCnt);
        assign do_pop       = pop_req[v] && (count_q != '0);
        assign overflow[v]  = push_req[v] && (count_q == FullCnt);
        assign underflow[v] = pop_req[v] && (count_q == '0);

        always_ff @(posedge clk) begin
            if (!reset_L) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= do_pop;
                if (do_push) begin
                    mem_q[wptr_q] <= data_in;
                    wptr_q        <= wptr_q + 1'b1;
                end
                if (do_pop) begin
                    data_q <= mem_q[rptr_q];
                    rptr_q <= rptr_q + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end

        assign rd_data[v] = data_q;
        assign valid[v]   = valid_q;
        assign full[v]    = (count_q >= FullThr);
        assign empty[v]   = (count_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            error_q <= 1'b0;
        end else if ((|overflow) || (|underflow)) begin
            error_q <= 1'b1;
        end
    end

    assign vc0_data  = rd_data[0];
    assign vc1_data  = rd_data[1];
    assign vc0_valid = valid[0];
    assign vc1_valid = valid[1];
    assign vc0_full  = full[0];
    assign vc1_full  = full[1];
    assign vc0_empty = empty[0];
    assign vc1_empty = empty[1];
    assign error     = error_q;

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Scoreboard bench for vc_fifo_bank: driver models each edge with queues, monitor compares.
module tb_vc_fifo_bank;

    localparam int WIDTH = 6;
    localparam int DEPTH = 4;
`ifdef VC_ALMOST_FULL_EN
    localparam int FullThr = DEPTH - 1;
`else
    localparam int FullThr = DEPTH;
`endif

    logic             clk;
    logic             reset_L;
    logic             push;
    logic [WIDTH-1:0] data_in;
    logic             vc0_pop;
    logic             vc1_pop;
    logic [WIDTH-1:0] vc0_data;
    logic [WIDTH-1:0] vc1_data;
    logic             vc0_valid;
    logic             vc1_valid;
    logic             vc0_full;
    logic             vc1_full;
    logic             vc0_empty;
    logic             vc1_empty;
    logic             error;

    vc_fifo_bank #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .push     (push),
        .data_in  (data_in),
        .vc0_pop  (vc0_pop),
        .vc1_pop  (vc1_pop),
        .vc0_data (vc0_data),
        .vc1_data (vc1_data),
        .vc0_valid(vc0_valid),
        .vc1_valid(vc1_valid),
        .vc0_full (vc0_full),
        .vc1_full (vc1_full),
        .vc0_empty(vc0_empty),
        .vc1_empty(vc1_empty),
        .error    (error)
    );

    typedef struct packed {
        logic             v0;
        logic             v1;
        logic             e0;
        logic             e1;
        logic             f0;
        logic             f1;
        logic             err;
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] mq0[$];
    logic [WIDTH-1:0] mq1[$];
    logic [WIDTH-1:0] m_d0, m_d1;
    logic             m_err;
    int               n_checks = 0;
    int               n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, apply the reference behaviour for the coming edge, queue the result.
    task automatic cycle(input logic rst_n, input logic p, input logic [WIDTH-1:0] din,
                         input logic p0, input logic p1);
        int   pre0, pre1;
        exp_t e;
        reset_L = rst_n;
        push    = p;
        data_in = din;
        vc0_pop = p0;
        vc1_pop = p1;
        pre0 = mq0.size();
        pre1 = mq1.size();
        e.v0 = 1'b0;
        e.v1 = 1'b0;
        if (!rst_n) begin
            mq0.delete();
            mq1.delete();
            m_d0  = '0;
            m_d1  = '0;
            m_err = 1'b0;
        end else begin
            if (p0) begin
                if (pre0 > 0) begin
                    m_d0 = mq0.pop_front();
                    e.v0 = 1'b1;
                end else m_err = 1'b1;
            end
            if (p1) begin
                if (pre1 > 0) begin
                    m_d1 = mq1.pop_front();
                    e.v1 = 1'b1;
                end else m_err = 1'b1;
            end
            if (p) begin
                if (din[4] == 1'b0) begin
                    if (pre0 < DEPTH) mq0.push_back(din);
                    else m_err = 1'b1;
                end else begin
                    if (pre1 < DEPTH) mq1.push_back(din);
                    else m_err = 1'b1;
                end
            end
        end
        e.e0  = (mq0.size() == 0);
        e.e1  = (mq1.size() == 0);
        e.f0  = (mq0.size() >= FullThr);
        e.f1  = (mq1.size() >= FullThr);
        e.err = m_err;
        e.d0  = m_d0;
        e.d1  = m_d1;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: one expected record per edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("vc0_valid", 32'(vc0_valid), 32'(e.v0));
                check("vc1_valid", 32'(vc1_valid), 32'(e.v1));
                check("vc0_empty", 32'(vc0_empty), 32'(e.e0));
                check("vc1_empty", 32'(vc1_empty), 32'(e.e1));
                check("vc0_full", 32'(vc0_full), 32'(e.f0));
                check("vc1_full", 32'(vc1_full), 32'(e.f1));
                check("error", 32'(error), 32'(e.err));
                check("vc0_data", 32'(vc0_data), 32'(e.d0));
                check("vc1_data", 32'(vc1_data), 32'(e.d1));
            end
        end
    end

    initial begin
        m_d0  = '0;
        m_d1  = '0;
        m_err = 1'b0;

        // Basic routing and 1-cycle read latency
        do_reset();
        do_reset();
        cycle(1'b1, 1'b1, 6'h01, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 6'h14, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        idle();

        // Fill VC0, overflow, drain in order
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, 6'(i), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 6'h05, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        idle();

        // Overflow while popping the full VC still drops the push
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 6'h28 + 6'(i), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 6'h0f, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);

        // Underflow on VC1, then a normal transfer; push+pop on empty VC1
        do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        idle();
        cycle(1'b1, 1'b1, 6'h15, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        idle();

        // Steady-state push+pop on VC0 with pointer wrap
        do_reset();
        cycle(1'b1, 1'b1, 6'h01, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 6'h02, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 6'h03 + 6'(i), 1'b1, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
        idle();

        // Reset mid-operation discards contents and clears error
        do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 6'h0a, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 6'h0b, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 6'h0c, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 6'h1d, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 6'h2e, 1'b1, 1'b1);
        idle();
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 99) < 55),
                  6'($urandom_range(0, 63)),
                  ($urandom_range(0, 99) < 45),
                  ($urandom_range(0, 99) < 45));
        end
        idle();

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_fifo_bank.md
VC_FIFO_BANK -- requirements
Module: vc_fifo_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, meaning word width in bits; bit 4 is the VC select bit.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning entries per VC FIFO (power of two, >= 2).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_L  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port push  input  1  word from the main-FIFO pop stage is valid this cycle.
REQ-006 The block SHALL have port data_in  input  WIDTH  pushed word.
REQ-007 The block SHALL have ports vc0_pop and vc1_pop, each input, 1 bit: consumer pop request per VC.
REQ-008 The block SHALL have ports vc0_data and vc1_data, each output, WIDTH bits: registered read data per VC.
REQ-009 The block SHALL have ports vc0_valid and vc1_valid, each output, 1 bit: the matching vcN_data holds a word popped last cycle.
REQ-010 The block SHALL have ports vc0_full and vc1_full, each output, 1 bit: back-pressure to the pop stage.
REQ-011 The block SHALL have ports vc0_empty and vc1_empty, each output, 1 bit: VC occupancy is zero.
REQ-012 The block SHALL have port error  output  1  sticky overflow/underflow flag.

Function
REQ-013 Routing SHALL send data_in to VC0 when data_in[4]=0 and to VC1 when data_in[4]=1; all WIDTH bits are stored unchanged.
REQ-014 Each VC SHALL be an independent circular FIFO with log2(DEPTH)-bit read/write pointers wrapping DEPTH-1 -> 0 and a log2(DEPTH)+1-bit occupancy count.
REQ-015 A push to a VC whose occupancy < DEPTH SHALL write at the write pointer and advance it in the same edge.
REQ-016 A push to a VC whose occupancy == DEPTH SHALL be dropped (no pointer or count change) and SHALL set error, even if that VC is popped in the same cycle.
REQ-017 A pop on a non-empty VC SHALL advance the read pointer and SHALL present the word on vcN_data with vcN_valid=1 on the following cycle (1-cycle latency).
REQ-018 A pop on an empty VC SHALL leave pointers unchanged, drive vcN_valid=0 next cycle and set error; a simultaneous push to that VC does not make it pop-able that cycle.
REQ-019 Simultaneous legal push and pop on the same VC SHALL keep occupancy unchanged and update both pointers.
REQ-020 vcN_data SHALL hold its last value when vcN_valid=0.
REQ-021 vcN_empty SHALL be 1 exactly when occupancy == 0, derived combinationally from the registered count.
REQ-022 The error flag, once set, SHALL remain 1 until reset.

Reset
REQ-023 While reset_L=0 at a rising edge, all pointers and counts SHALL clear to 0, and vcN_data SHALL clear to 0.
REQ-024 While reset_L=0 at a rising edge, vcN_valid, vcN_full and error SHALL clear to 0, and vcN_empty SHALL be 1.
REQ-025 Reset SHALL take priority over push/pop in the same cycle; stored contents SHALL be discarded mid-operation.

Configuration
REQ-026 The macro VC_ALMOST_FULL_EN SHALL control the full threshold.
REQ-027 With VC_ALMOST_FULL_EN defined, vcN_full SHALL be 1 when occupancy >= DEPTH-1, leaving one slot to absorb a push already in flight from the pop stage.
REQ-028 Without VC_ALMOST_FULL_EN, vcN_full SHALL be 1 only when occupancy == DEPTH.
REQ-029 The overflow rule in REQ-016 SHALL be identical in both builds.

Verification
REQ-030 Reset, then push 0x01 (VC0) and 0x14 (VC1), then pop both: vc0_data=0x01 and vc1_data=0x14 with both valid=1 one cycle after the pop; error=0.
REQ-031 Push 0x01..0x04 to VC0 (DEPTH=4): vc0_full=1 after the 4th push, or after the 3rd with VC_ALMOST_FULL_EN; a 5th push is dropped, error=1, and the four pops return 0x01..0x04 in order.
REQ-032 Pop VC1 while empty: vc1_valid=0 next cycle and error=1; pointers are unchanged, so a later push/pop of 0x15 returns 0x15.
REQ-033 Fill VC0 to 2 entries, then push and pop VC0 in the same cycle for 6 cycles: occupancy stays 2, pointers wrap, output order is preserved, and vc0_full never asserts.
REQ-034 Hold 3 words in VC0 and 1 in VC1, set error via underflow, then drive reset_L=0 for one cycle: all empty=1, full=0, valid=0, error=0, and data=0 on the next cycle.
